// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat press pulses while held).
package btn_pkg;

    // Debounce FSM states: released, checking press, held, checking release.
    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        HELD  = 2'd2,
        CHK_R = 2'd3
    } db_state_e;

    // Default timing at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 200 ms

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered
// press/release pulses and, with BTN_AUTOREPEAT_EN, a repeat counter.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic rclock,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_o
);

    localparam int CW = cnt_w(DEBOUNCE_CYCLES);

    // Elaboration-time parameter sanity check.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_debounce_ch: timing parameters must be >= 1");
    end

    logic          s1_q, s2_q;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d, press_n;
    logic          rel_q, rel_d;

    // Debounce next-state: count consecutive cycles that disagree with the level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            REL: if (s2_q) begin
                // A one-cycle debounce window is already satisfied by this sample.
                if (DEBOUNCE_CYCLES <= 1) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    state_d = CHK_P;
                    cnt_d   = CW'(1);
                end
            end
            CHK_P: if (!s2_q) begin
                state_d = REL;
                cnt_d   = '0;
            end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                state_d = HELD;
                cnt_d   = '0;
                press_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            HELD: if (!s2_q) begin
                if (DEBOUNCE_CYCLES <= 1) begin
                    state_d = REL;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    state_d = CHK_R;
                    cnt_d   = CW'(1);
                end
            end
            CHK_R: if (s2_q) begin
                state_d = HELD;
                cnt_d   = '0;
            end else if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                state_d = REL;
                cnt_d   = '0;
                rel_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = cnt_w(RMAX);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_first_q, rpt_first_d;
    logic          rpt_fire;

    // Repeat timer: first interval REPEAT_DELAY, then REPEAT_PERIOD, while held.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
        rpt_fire    = 1'b0;
        if (state_d == REL || press_d) begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end else if (state_q == HELD || state_q == CHK_R) begin
            if (int'(rpt_q) + 1 >= (rpt_first_q ? REPEAT_DELAY : REPEAT_PERIOD)) begin
                rpt_fire    = 1'b1;
                rpt_d       = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_d = rpt_q + RW'(1);
            end
        end
        press_n = press_d | (rpt_fire & ~rel_d);
    end

    // Repeat timer registers.
    always_ff @(posedge rclock) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    // Without auto-repeat only the debounced rising edge produces a press.
    always_comb press_n = press_d;
`endif

    // Synchroniser, FSM state and registered pulse outputs.
    always_ff @(posedge rclock) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= REL;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_n;
            rel_q   <= rel_d;
        end
    end

    assign level     = (state_q == HELD) || (state_q == CHK_R);
    assign press     = press_q;
    assign release_o = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button conditioners. The falling-edge pulse port is
// called release_o because "release" is a reserved word in SystemVerilog.
// Optional feature macro: BTN_AUTOREPEAT_EN.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             rclock,
    input  logic             rst,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_o
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .rclock   (rclock),
            .rst      (rst),
            .btn_in   (button[g]),
            .level    (level[g]),
            .press    (press[g]),
            .release_o(release_o[g])
        );
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Per-button input conditioner for the board push-buttons. It synchronises each raw button to `rclock`, debounces it, and produces a clean level plus a single-cycle press pulse. It sits directly upstream of the dice-guess game core: `press` drives the core's roll, advance and clear button inputs. The core therefore sees exactly one event per physical press, with no bounce or metastability.

## Interface
- `N_BTN`, 4, number of button channels
- `DEBOUNCE_CYCLES`, 1000000, consecutive stable cycles required before the level changes (20 ms at 50 MHz); must be ≥ 1
- `REPEAT_DELAY`, 25000000, cycles from press pulse to first auto-repeat pulse (used only with `BTN_AUTOREPEAT_EN`)
- `REPEAT_PERIOD`, 10000000, cycles between subsequent auto-repeat pulses (used only with `BTN_AUTOREPEAT_EN`)

Ports:
- `rclock`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `button`  in  N_BTN  raw asynchronous button inputs, active-high
- `level`  out  N_BTN  debounced button state
- `press`  out  N_BTN  one-cycle pulse on each debounced rising edge, plus auto-repeat pulses when enabled
- `release`  out  N_BTN  one-cycle pulse on each debounced falling edge

## Operation
- Each channel is independent and identical.
- Synchroniser: two flops, `s1 <= button[i]`, `s2 <= s1`. `s2` is the sampled value.
- Debounce FSM per channel, with states `REL`, `CHK_P`, `HELD`, `CHK_R`:
  - `REL`: `level=0`. If `s2=1`, go to `CHK_P` with count=1.
  - `CHK_P`: if `s2=0`, return to `REL` and clear count. Otherwise count++. When count reaches `DEBOUNCE_CYCLES`, go to `HELD`, set `level=1` and pulse `press`.
  - `HELD`: `level=1`. If `s2=0`, go to `CHK_R` with count=1.
  - `CHK_R`: if `s2=1`, return to `HELD` and clear count. Otherwise count++. When count reaches `DEBOUNCE_CYCLES`, go to `REL`, set `level=0` and pulse `release`.
- Any single-cycle glitch during a `CHK_*` state restarts the count from zero. There is no partial credit.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter saturates and never wraps.
- `press` and `release` are registered outputs. They are never both high on the same channel in the same cycle.

## Timing
- Reset (`rst=1` at a `rclock` edge):
  - all FSMs go to `REL`; counters and synchroniser flops go to 0
  - `level`, `press` and `release` are all 0 in the following cycle
- Reset mid-press discards the press. A button still held after reset is released produces a fresh `press` after the full latency.
- Latency: raw `button` rises before edge k and stays stable. Then `level` and `press` go high after edge k+1+`DEBOUNCE_CYCLES`, which is 2 synchroniser cycles + `DEBOUNCE_CYCLES` − 1. `release` follows the same rule on the falling edge.
- `press` width is exactly one cycle. The minimum spacing between two `press` pulses on one channel (without repeat) is 2×`DEBOUNCE_CYCLES`.
- Simultaneous presses on different channels give independent pulses, which may land in the same cycle.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - each channel gets a repeat counter that runs while in `HELD` or `CHK_R`
  - after the initial `press`, further `press` pulses occur `REPEAT_DELAY` cycles later, then every `REPEAT_PERIOD` cycles
  - the counter clears on entry to `REL` and on `rst`
  - a repeat pulse is suppressed in the cycle a `release` fires
- `BTN_AUTOREPEAT_EN` undefined:
  - no repeat logic is synthesised
  - exactly one `press` per debounced press; `REPEAT_*` parameters are ignored

## Structure
- Package `btn_pkg`:
  - debounce state enum (`REL`, `CHK_P`, `HELD`, `CHK_R`)
  - a counter-width helper function
  - default timing constants at 50 MHz
- Sub-module `btn_debounce_ch`: one channel containing the synchroniser, FSM and optional repeat counter. The top instantiates it `N_BTN` times via generate.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.
- Clean press: `button[0]` goes 0→1 at cycle 0 and holds → `press[0]` is a single pulse and `level[0]=1` from cycle 5. Other channels stay 0.
- Bounce: `button[1]` toggles 1,0,1,0 on alternate cycles, then holds 1 → no pulse during the bounce. `press[1]` fires exactly once, 5 cycles after the last rising transition.
- Release: hold `button[2]` for 20 cycles, then drop it → one `release[2]` pulse 5 cycles after the drop. `level[2]` falls in the same cycle as that pulse. No extra `press`.
- Reset mid-debounce: assert `rst` 2 cycles into `CHK_P` while the button is held → all outputs 0. After `rst` deasserts, `press` fires 5 cycles later.
- Auto-repeat (macro defined): hold `button[3]` for 30 cycles → `press[3]` at cycles 5, 15, 18, 21, 24, 27, 30 (repeat counter running). With the macro undefined → only cycle 5.
- Simultaneous: `button=4'b1111` at cycle 0 → all four `press` bits pulse in the same cycle.
